// File: rtl/spi_adapter_pkg.sv
// spi_adapter_pkg: header bit positions and payload width for the SPI push/pull adapter
package spi_adapter_pkg;
  function automatic int wr_val_bit(input int nbits);
    return nbits - 1;
  endfunction
  function automatic int rd_val_bit(input int nbits);
    return nbits - 1;
  endfunction
  function automatic int spc_bit(input int nbits);
    return nbits - 2;
  endfunction
  function automatic int payload_w(input int nbits);
    return nbits - 2;
  endfunction
endpackage

// File: rtl/spi_adapter_queue.sv
// spi_adapter_queue: circular-buffer queue with val/rdy ports and no bypass
module spi_adapter_queue #(
  parameter int nbits_data  = 6,
  parameter int num_entries = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enq_val,
  output logic                                 enq_rdy,
  input  logic [nbits_data-1:0]                enq_msg,
  output logic                                 deq_val,
  input  logic                                 deq_rdy,
  output logic [nbits_data-1:0]                deq_msg,
  output logic                                 full,
  output logic [$clog2(num_entries+1)-1:0]     count
);
  localparam int CW = $clog2(num_entries + 1);
  localparam int PW = num_entries > 1 ? $clog2(num_entries) : 1;
  logic [nbits_data-1:0] mem_q [num_entries];
  logic [nbits_data-1:0] mem_d [num_entries];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic enq, deq;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(num_entries - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full    = count_q == CW'(num_entries);
  assign count   = count_q;
  assign enq_rdy = !full;
  assign deq_val = count_q != '0;
  assign deq_msg = mem_q[head_q];
  assign enq     = enq_val && !full;
  assign deq     = deq_val && deq_rdy;
  always_comb begin
    mem_d   = mem_q;
    head_d  = deq ? nxt(head_q) : head_q;
    tail_d  = enq ? nxt(tail_q) : tail_q;
    count_d = count_q + CW'(enq) - CW'(deq);
    if (enq) mem_d[tail_q] = enq_msg;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/spi_minion_push_pull_adapter.sv
// spi_minion_push_pull_adapter: turns SPI minion push/pull pulses into buffered
// request/response val/rdy streams with flow-control headers on outgoing packets.
module spi_minion_push_pull_adapter
  import spi_adapter_pkg::*;
#(
  parameter int nbits       = 8,
  parameter int num_entries = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_en,
  input  logic [nbits-1:0]      push_msg,
  input  logic                  pull_en,
  output logic [nbits-1:0]      pull_msg,
  output logic                  req_val,
  input  logic                  req_rdy,
  output logic [nbits-3:0]      req_msg,
  input  logic                  resp_val,
  output logic                  resp_rdy,
  input  logic [nbits-3:0]      resp_msg,
  output logic                  overflow
);
  localparam int WR_VAL_BIT = wr_val_bit(nbits);
  localparam int RD_VAL_BIT = rd_val_bit(nbits);
  localparam int SPC_BIT    = spc_bit(nbits);
  localparam int DW         = payload_w(nbits);
  localparam int CW         = $clog2(num_entries + 1);
  logic          wr_val, req_enq_rdy, req_full, rsp_val, rsp_full;
  logic [DW-1:0] rsp_head;
  logic [CW-1:0] req_cnt, rsp_cnt;
  logic          overflow_q, overflow_d;
  logic          unused;
  assign wr_val = push_msg[WR_VAL_BIT];
  spi_adapter_queue #(.nbits_data(DW), .num_entries(num_entries)) u_req (
    .clk(clk), .reset(reset),
    .enq_val(push_en && wr_val), .enq_rdy(req_enq_rdy), .enq_msg(push_msg[DW-1:0]),
    .deq_val(req_val), .deq_rdy(req_rdy), .deq_msg(req_msg),
    .full(req_full), .count(req_cnt)
  );
  spi_adapter_queue #(.nbits_data(DW), .num_entries(num_entries)) u_rsp (
    .clk(clk), .reset(reset),
    .enq_val(resp_val), .enq_rdy(resp_rdy), .enq_msg(resp_msg),
    .deq_val(rsp_val), .deq_rdy(pull_en), .deq_msg(rsp_head),
    .full(rsp_full), .count(rsp_cnt)
  );
  assign unused = ^{req_enq_rdy, req_cnt, rsp_cnt, rsp_full};
  always_comb begin
    pull_msg             = '0;
    pull_msg[RD_VAL_BIT] = rsp_val;
    pull_msg[SPC_BIT]    = !req_full;
    pull_msg[DW-1:0]     = rsp_val ? rsp_head : '0;
  end
  // fullness is taken from cycle-start state, so a same-cycle dequeue never rescues a push
  assign overflow_d = overflow_q || (push_en && wr_val && req_full);
  assign overflow   = overflow_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end
endmodule

// File: tb/tb_spi_minion_push_pull_adapter.sv
// tb_spi_minion_push_pull_adapter: directed scenario checks for the SPI push/pull adapter
module tb_spi_minion_push_pull_adapter;
  logic       clk = 0, reset = 1;
  logic       push_en = 0, pull_en = 0, req_rdy = 0, resp_val = 0;
  logic [7:0] push_msg = 0;
  logic [5:0] resp_msg = 0;
  logic [7:0] pull_msg;
  logic [5:0] req_msg;
  logic       req_val, resp_rdy, overflow;
  int errors = 0, checks = 0;

  spi_minion_push_pull_adapter #(.nbits(8), .num_entries(2)) dut (
    .clk(clk), .reset(reset), .push_en(push_en), .push_msg(push_msg),
    .pull_en(pull_en), .pull_msg(pull_msg), .req_val(req_val), .req_rdy(req_rdy),
    .req_msg(req_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_msg(resp_msg), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] m);
    push_en = 1; push_msg = m;
    tick();
    push_en = 0; push_msg = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (req_val !== 1'b0) begin errors++; $display("FAIL rst_req_val got=%b exp=0", req_val); end
    checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL rst_resp_rdy got=%b exp=1", resp_rdy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    tick(); reset = 0; tick();
    pull_en = 1;
    checks++; if (pull_msg !== 8'h40) begin errors++; $display("FAIL rst_pull got=%h exp=40", pull_msg); end
    tick(); pull_en = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single_push();
    push_en = 1; push_msg = 8'h95;
    checks++; if (req_val !== 1'b0) begin errors++; $display("FAIL no_bypass got=%b exp=0", req_val); end
    tick(); push_en = 0;
    checks++; if (req_val !== 1'b1 || req_msg !== 6'h15) begin errors++; $display("FAIL single_push got=%b/%h exp=1/15", req_val, req_msg); end
    tick();
    checks++; if (req_val !== 1'b1 || req_msg !== 6'h15) begin errors++; $display("FAIL single_hold got=%b/%h exp=1/15", req_val, req_msg); end
    req_rdy = 1; tick(); req_rdy = 0;
    checks++; if (req_val !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", req_val); end
    push(8'h3F);
    checks++; if (req_val !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL no_wr_val got=%b/%b exp=0/0", req_val, overflow); end
  endtask

  task automatic test_overflow();
    push(8'h81); push(8'h82);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pre_ovf got=%b exp=0", overflow); end
    push(8'h83);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (pull_msg !== 8'h00) begin errors++; $display("FAIL spc_full got=%h exp=00", pull_msg); end
    req_rdy = 1;
    checks++; if (req_val !== 1'b1 || req_msg !== 6'h01) begin errors++; $display("FAIL drain1 got=%b/%h exp=1/01", req_val, req_msg); end
    tick();
    checks++; if (req_val !== 1'b1 || req_msg !== 6'h02) begin errors++; $display("FAIL drain2 got=%b/%h exp=1/02", req_val, req_msg); end
    tick(); req_rdy = 0;
    checks++; if (req_val !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL drain_end got=%b/%b exp=0/1", req_val, overflow); end
  endtask

  task automatic test_resp();
    push(8'h84); push(8'h85);
    resp_val = 1; resp_msg = 6'h2A; tick();
    resp_msg = 6'h01;
    checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL resp_rdy_one got=%b exp=1", resp_rdy); end
    tick(); resp_val = 0;
    checks++; if (resp_rdy !== 1'b0) begin errors++; $display("FAIL resp_full got=%b exp=0", resp_rdy); end
    pull_en = 1;
    checks++; if (pull_msg !== 8'hAA) begin errors++; $display("FAIL pull1 got=%h exp=AA", pull_msg); end
    tick();
    checks++; if (pull_msg !== 8'h81) begin errors++; $display("FAIL pull2 got=%h exp=81", pull_msg); end
    tick();
    checks++; if (pull_msg !== 8'h00) begin errors++; $display("FAIL pull3 got=%h exp=00", pull_msg); end
    tick(); pull_en = 0;
    checks++; if (resp_rdy !== 1'b1) begin errors++; $display("FAIL resp_rdy_back got=%b exp=1", resp_rdy); end
  endtask

  task automatic test_simul();
    resp_val = 1; resp_msg = 6'h11; tick();
    resp_msg = 6'h22; pull_en = 1;
    checks++; if (pull_msg !== 8'h91) begin errors++; $display("FAIL simul_old got=%h exp=91", pull_msg); end
    tick(); resp_val = 0;
    checks++; if (pull_msg !== 8'hA2) begin errors++; $display("FAIL simul_new got=%h exp=A2", pull_msg); end
    tick();
    resp_val = 1; resp_msg = 6'h05;
    checks++; if (pull_msg !== 8'h00) begin errors++; $display("FAIL simul_empty got=%h exp=00", pull_msg); end
    tick(); resp_val = 0; pull_en = 0;
    checks++; if (pull_msg !== 8'h85) begin errors++; $display("FAIL simul_kept got=%h exp=85", pull_msg); end
  endtask

  task automatic test_reset_mid();
    #2 reset = 1;
    #1;
    checks++; if (req_val !== 1'b0 || resp_rdy !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL async_rst got=%b/%b/%b exp=0/1/0", req_val, resp_rdy, overflow); end
    checks++; if (pull_msg !== 8'h40) begin errors++; $display("FAIL async_rst_pull got=%h exp=40", pull_msg); end
    tick(); reset = 0; tick();
    pull_en = 1;
    checks++; if (pull_msg !== 8'h40) begin errors++; $display("FAIL post_rst_pull got=%h exp=40", pull_msg); end
    tick(); pull_en = 0;
  endtask

  task automatic test_full_deq_push();
    push(8'h81); push(8'h82);
    req_rdy = 1; push(8'h83);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_deq_ovf got=%b exp=1", overflow); end
    checks++; if (req_val !== 1'b1 || req_msg !== 6'h02) begin errors++; $display("FAIL full_deq_head got=%b/%h exp=1/02", req_val, req_msg); end
    tick(); req_rdy = 0;
    checks++; if (req_val !== 1'b0) begin errors++; $display("FAIL full_deq_dropped got=%b exp=0", req_val); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overflow();
    test_resp();
    test_simul();
    test_reset_mid();
    test_full_deq_push();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
